// File: rtl/opicorv32_mem_arbiter_pkg.sv
// Shared types and constants for the two-port native memory arbiter.
package opicorv32_mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int unsigned PORT_CORE = 0;
    localparam int unsigned PORT_DBG  = 1;

    localparam logic [31:0] ABORT_RDATA = 32'hDEAD_BEEF;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_CORE = 2'b01;
    localparam logic [1:0] GRANT_DBG  = 2'b10;

    function automatic logic [1:0] grant_onehot(input logic dbg_wins);
        return dbg_wins ? GRANT_DBG : GRANT_CORE;
    endfunction

endpackage

// File: rtl/opicorv32_mem_arbiter_pick.sv
// Winner selection for the memory arbiter: fixed priority to the core port,
// with a saturating starvation counter that hands one grant to the debug port.
module opicorv32_mem_arb_pick
    import opicorv32_mem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic m0_valid,
    input  logic m1_valid,
    input  logic arb_en,
    output logic pick_valid,
    output logic pick_port
);

    logic [3:0] starve_cnt_q;
    logic [3:0] starve_cnt_d;
    logic       starved;

    always_comb begin
        starved      = (starve_cnt_q == 4'(STARVE_LIMIT));
        pick_valid   = m0_valid | m1_valid;
        pick_port    = m1_valid & (~m0_valid | starved);
        starve_cnt_d = starve_cnt_q;
        if (arb_en && pick_valid) begin
            if (pick_port == 1'(PORT_DBG)) begin
                starve_cnt_d = '0;
            end else if (m1_valid && !starved) begin
                starve_cnt_d = starve_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/opicorv32_mem_arbiter.sv
// Two-port arbiter in front of the native memory bus, one transaction in flight.
// Optional bus watchdog enabled by defining OPICORV32_MEM_TIMEOUT_EN.
module opicorv32_mem_arbiter
    import opicorv32_mem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,

    output logic [1:0]  grant,
    output logic        err
);

    if (STARVE_LIMIT == 0 || STARVE_LIMIT > 15 || TIMEOUT_CYCLES == 0) begin : g_bad_params
        $error("opicorv32_mem_arbiter: parameter out of range");
    end

    arb_state_t  state_q, state_d;
    logic        mem_valid_q, mem_valid_d;
    logic        mem_instr_q, mem_instr_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [1:0]  grant_q, grant_d;

    logic        pick_valid;
    logic        pick_port;
    logic        busy;
    logic        abort_now;
    logic        done;
    logic [31:0] resp_rdata;

    opicorv32_mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .clk        (clk),
        .reset      (reset),
        .m0_valid   (m0_valid),
        .m1_valid   (m1_valid),
        .arb_en     (state_q == IDLE),
        .pick_valid (pick_valid),
        .pick_port  (pick_port)
    );

    assign busy = (state_q == BUSY);

`ifdef OPICORV32_MEM_TIMEOUT_EN
    localparam int unsigned WAIT_W =
        ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              err_q, err_d;

    assign abort_now = busy && (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES));

    // A real mem_ready in the abort cycle wins, so the error only latches without it.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        if (state_q == IDLE) begin
            wait_cnt_d = '0;
        end else if (!mem_ready) begin
            if (abort_now) begin
                err_d = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign err = err_q;
`else
    assign abort_now = 1'b0;
    assign err       = 1'b0;
`endif

    assign done       = busy && (mem_ready || abort_now);
    assign resp_rdata = (abort_now && !mem_ready) ? ABORT_RDATA : mem_rdata;

    always_comb begin
        state_d     = state_q;
        mem_valid_d = mem_valid_q;
        mem_instr_d = mem_instr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        grant_d     = grant_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    if (pick_port) begin
                        mem_instr_d = m1_instr;
                        mem_addr_d  = m1_addr;
                        mem_wdata_d = m1_wdata;
                        mem_wstrb_d = m1_wstrb;
                    end else begin
                        mem_instr_d = m0_instr;
                        mem_addr_d  = m0_addr;
                        mem_wdata_d = m0_wdata;
                        mem_wstrb_d = m0_wstrb;
                    end
                    mem_valid_d = 1'b1;
                    grant_d     = grant_onehot(pick_port);
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (done) begin
                    mem_valid_d = 1'b0;
                    grant_d     = GRANT_NONE;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_valid_q <= 1'b0;
            mem_instr_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            grant_q     <= GRANT_NONE;
        end else begin
            state_q     <= state_d;
            mem_valid_q <= mem_valid_d;
            mem_instr_q <= mem_instr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            grant_q     <= grant_d;
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_instr = mem_instr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign grant     = grant_q;

    // Response path is combinational so the requester sees ready in the bus cycle.
    assign m0_ready = done && grant_q[PORT_CORE];
    assign m1_ready = done && grant_q[PORT_DBG];
    assign m0_rdata = (busy && grant_q[PORT_CORE]) ? resp_rdata : '0;
    assign m1_rdata = (busy && grant_q[PORT_DBG])  ? resp_rdata : '0;

endmodule

// File: tb/tb_opicorv32_mem_arbiter.sv
// Directed bench for opicorv32_mem_arbiter: per-cycle vector table plus
// hand-written sequences for reset-in-flight and the bus watchdog.
module tb_opicorv32_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_valid, m0_instr;
    logic [31:0] m0_addr, m0_wdata;
    logic [3:0]  m0_wstrb;
    logic        m0_ready;
    logic [31:0] m0_rdata;
    logic        m1_valid, m1_instr;
    logic [31:0] m1_addr, m1_wdata;
    logic [3:0]  m1_wstrb;
    logic        m1_ready;
    logic [31:0] m1_rdata;
    logic        mem_valid, mem_instr;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [1:0]  grant;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    opicorv32_mem_arbiter #(
        .STARVE_LIMIT   (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_valid  (m0_valid),
        .m0_instr  (m0_instr),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_wstrb  (m0_wstrb),
        .m0_ready  (m0_ready),
        .m0_rdata  (m0_rdata),
        .m1_valid  (m1_valid),
        .m1_instr  (m1_instr),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_wstrb  (m1_wstrb),
        .m1_ready  (m1_ready),
        .m1_rdata  (m1_rdata),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .grant     (grant),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        m0_valid;
        logic        m0_instr;
        logic [31:0] m0_addr;
        logic [31:0] m0_wdata;
        logic [3:0]  m0_wstrb;
        logic        m1_valid;
        logic        m1_instr;
        logic [31:0] m1_addr;
        logic [31:0] m1_wdata;
        logic [3:0]  m1_wstrb;
        logic        mem_ready;
        logic [31:0] mem_rdata;
        logic        e_mem_valid;
        logic [1:0]  e_grant;
        logic        e_m0_ready;
        logic [31:0] e_m0_rdata;
        logic        e_m1_ready;
        logic [31:0] e_m1_rdata;
        logic        chk_bus;
        logic        e_instr;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_wstrb;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        m0_valid  = v.m0_valid;
        m0_instr  = v.m0_instr;
        m0_addr   = v.m0_addr;
        m0_wdata  = v.m0_wdata;
        m0_wstrb  = v.m0_wstrb;
        m1_valid  = v.m1_valid;
        m1_instr  = v.m1_instr;
        m1_addr   = v.m1_addr;
        m1_wdata  = v.m1_wdata;
        m1_wstrb  = v.m1_wstrb;
        mem_ready = v.mem_ready;
        mem_rdata = v.mem_rdata;
    endtask

    task automatic set_in(input logic v0, input logic [31:0] a0, input logic v1,
                          input logic [31:0] a1, input logic mr, input logic [31:0] rd);
        vec_t v;
        v = '0;
        v.m0_valid  = v0;
        v.m0_addr   = a0;
        v.m1_valid  = v1;
        v.m1_addr   = a1;
        v.mem_ready = mr;
        v.mem_rdata = rd;
        drive(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        chk($sformatf("v%0d mem_valid", i), 32'(mem_valid), 32'(v.e_mem_valid));
        chk($sformatf("v%0d grant", i),     32'(grant),     32'(v.e_grant));
        chk($sformatf("v%0d m0_ready", i),  32'(m0_ready),  32'(v.e_m0_ready));
        chk($sformatf("v%0d m0_rdata", i),  m0_rdata,       v.e_m0_rdata);
        chk($sformatf("v%0d m1_ready", i),  32'(m1_ready),  32'(v.e_m1_ready));
        chk($sformatf("v%0d m1_rdata", i),  m1_rdata,       v.e_m1_rdata);
        if (v.chk_bus) begin
            chk($sformatf("v%0d mem_instr", i), 32'(mem_instr), 32'(v.e_instr));
            chk($sformatf("v%0d mem_addr", i),  mem_addr,       v.e_addr);
            chk($sformatf("v%0d mem_wdata", i), mem_wdata,      v.e_wdata);
            chk($sformatf("v%0d mem_wstrb", i), 32'(mem_wstrb), 32'(v.e_wstrb));
        end
    endtask

    task automatic pulse_reset();
        #1 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic build_vectors();
        vec_t v;
        logic dbg;
        // Port-0 fetch, memory answers on the third bus cycle.
        v = '0; v.m0_valid = 1'b1; v.m0_instr = 1'b1; v.m0_addr = 32'h40;
        vecs.push_back(v);
        v.e_mem_valid = 1'b1; v.e_grant = 2'b01;
        v.chk_bus = 1'b1; v.e_instr = 1'b1; v.e_addr = 32'h40;
        vecs.push_back(v);
        vecs.push_back(v);
        v.mem_ready = 1'b1; v.mem_rdata = 32'h1234_5678;
        v.e_m0_ready = 1'b1; v.e_m0_rdata = 32'h1234_5678;
        vecs.push_back(v);
        // Stray mem_ready while idle must be ignored.
        v = '0; v.mem_ready = 1'b1; v.mem_rdata = 32'hFFFF_0000;
        vecs.push_back(v);
        v = '0;
        vecs.push_back(v);
        // Both ports busy: four core grants, then one debug grant, twice.
        for (int t = 0; t < 10; t++) begin
            dbg = (t == 4) || (t == 9);
            v = '0;
            v.m0_valid = 1'b1; v.m0_addr = 32'h200; v.m0_wdata = 32'h11;
            v.m1_valid = 1'b1; v.m1_addr = 32'h300; v.m1_wdata = 32'h22; v.m1_wstrb = 4'h3;
            vecs.push_back(v);
            v.mem_ready = 1'b1; v.mem_rdata = 32'h1000 + 32'(t);
            v.e_mem_valid = 1'b1;
            v.e_grant = dbg ? 2'b10 : 2'b01;
            v.e_m0_ready = !dbg; v.e_m0_rdata = dbg ? 32'h0 : 32'h1000 + 32'(t);
            v.e_m1_ready = dbg;  v.e_m1_rdata = dbg ? 32'h1000 + 32'(t) : 32'h0;
            v.chk_bus = 1'b1;
            v.e_addr  = dbg ? 32'h300 : 32'h200;
            v.e_wdata = dbg ? 32'h22 : 32'h11;
            v.e_wstrb = dbg ? 4'h3 : 4'h0;
            vecs.push_back(v);
        end
        // Debug write; requester misbehaves while granted, bus must stay put.
        v = '0;
        v.m1_valid = 1'b1; v.m1_addr = 32'h100; v.m1_wdata = 32'hA5A5_A5A5; v.m1_wstrb = 4'hF;
        vecs.push_back(v);
        v = '0; v.m1_addr = 32'hBAD;
        v.e_mem_valid = 1'b1; v.e_grant = 2'b10;
        v.chk_bus = 1'b1; v.e_addr = 32'h100; v.e_wdata = 32'hA5A5_A5A5; v.e_wstrb = 4'hF;
        for (int k = 0; k < 3; k++) vecs.push_back(v);
        v.mem_ready = 1'b1; v.mem_rdata = 32'hCAFE_0001;
        v.e_m1_ready = 1'b1; v.e_m1_rdata = 32'hCAFE_0001;
        vecs.push_back(v);
        v = '0;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        vec_t z;
        logic [1:0] eg;
        z = '0;
        reset = 1'b1;
        drive(z);
        build_vectors();
        #12;
        chk("rst mem_valid", 32'(mem_valid), 32'h0);
        chk("rst grant",     32'(grant),     32'h0);
        chk("rst mem_addr",  mem_addr,       32'h0);
        chk("rst mem_wdata", mem_wdata,      32'h0);
        chk("rst mem_wstrb", 32'(mem_wstrb), 32'h0);
        chk("rst mem_instr", 32'(mem_instr), 32'h0);
        chk("rst m0_ready",  32'(m0_ready),  32'h0);
        chk("rst m1_ready",  32'(m1_ready),  32'h0);
        chk("rst err",       32'(err),       32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step();
            drive(vecs[i]);
            @(negedge clk);
            check_vec(i, vecs[i]);
        end

        // Reset while a transaction is in flight.
        step(); set_in(1'b1, 32'h400, 1'b1, 32'h500, 1'b0, 32'h0);
        @(negedge clk);
        step(); set_in(1'b1, 32'h400, 1'b1, 32'h500, 1'b1, 32'h77);
        @(negedge clk);
        chk("pre txn grant", 32'(grant), 32'h1);
        step(); set_in(1'b1, 32'h400, 1'b1, 32'h500, 1'b0, 32'h0);
        @(negedge clk);
        step();
        @(negedge clk);
        chk("busy before reset", 32'(mem_valid), 32'h1);
        mem_ready = 1'b1;
        #1;
        chk("ready before reset", 32'(m0_ready), 32'h1);
        reset = 1'b1;
        #1;
        chk("async rst mem_valid", 32'(mem_valid), 32'h0);
        chk("async rst grant",     32'(grant),     32'h0);
        chk("async rst m0_ready",  32'(m0_ready),  32'h0);
        chk("async rst mem_addr",  mem_addr,       32'h0);
        drive(z);
        @(negedge clk);
        reset = 1'b0;
        // A cleared starvation count gives exactly four core grants first.
        for (int k = 0; k < 5; k++) begin
            eg = (k == 4) ? 2'b10 : 2'b01;
            step(); set_in(1'b1, 32'h600, 1'b1, 32'h700, 1'b0, 32'h0);
            @(negedge clk);
            chk($sformatf("post rst idle %0d", k), 32'(grant), 32'h0);
            step(); set_in(1'b1, 32'h600, 1'b1, 32'h700, 1'b1, 32'h0);
            @(negedge clk);
            chk($sformatf("post rst grant %0d", k), 32'(grant), 32'(eg));
        end
        step(); drive(z);
        @(negedge clk);

`ifdef OPICORV32_MEM_TIMEOUT_EN
        // Silent memory: eight waiting cycles, then an abort response.
        step(); set_in(1'b1, 32'h800, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        for (int k = 1; k <= 8; k++) begin
            step();
            @(negedge clk);
            chk($sformatf("to wait ready %0d", k), 32'(m0_ready), 32'h0);
            chk($sformatf("to wait valid %0d", k), 32'(mem_valid), 32'h1);
        end
        step();
        @(negedge clk);
        chk("abort m0_ready", 32'(m0_ready), 32'h1);
        chk("abort m0_rdata", m0_rdata,      32'hDEAD_BEEF);
        chk("abort m1_ready", 32'(m1_ready), 32'h0);
        step(); drive(z);
        @(negedge clk);
        chk("abort err",       32'(err),       32'h1);
        chk("abort mem_valid", 32'(mem_valid), 32'h0);
        chk("abort grant",     32'(grant),     32'h0);
        step(); set_in(1'b1, 32'h804, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        step(); set_in(1'b1, 32'h804, 1'b0, 32'h0, 1'b1, 32'h1234);
        @(negedge clk);
        chk("after abort ready", 32'(m0_ready), 32'h1);
        chk("after abort rdata", m0_rdata,      32'h1234);
        chk("after abort addr",  mem_addr,      32'h804);
        step(); drive(z);
        @(negedge clk);
        chk("err sticky", 32'(err), 32'h1);
        pulse_reset();
        chk("err cleared", 32'(err), 32'h0);
        // mem_ready exactly in the abort cycle completes normally.
        step(); set_in(1'b1, 32'h900, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        for (int k = 1; k <= 8; k++) begin
            step();
            @(negedge clk);
        end
        step(); set_in(1'b1, 32'h900, 1'b0, 32'h0, 1'b1, 32'h55AA_55AA);
        @(negedge clk);
        chk("race m0_ready", 32'(m0_ready), 32'h1);
        chk("race m0_rdata", m0_rdata,      32'h55AA_55AA);
        step(); drive(z);
        @(negedge clk);
        chk("race err",       32'(err),       32'h0);
        chk("race mem_valid", 32'(mem_valid), 32'h0);
`else
        // Without the watchdog a silent memory simply stalls the bus.
        step(); set_in(1'b1, 32'h800, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        for (int k = 1; k <= 20; k++) begin
            step();
            @(negedge clk);
        end
        chk("stall mem_valid", 32'(mem_valid), 32'h1);
        chk("stall m0_ready",  32'(m0_ready),  32'h0);
        chk("stall err",       32'(err),       32'h0);
        step(); set_in(1'b1, 32'h800, 1'b0, 32'h0, 1'b1, 32'h4242);
        @(negedge clk);
        chk("stall done ready", 32'(m0_ready), 32'h1);
        chk("stall done rdata", m0_rdata,      32'h4242);
        step(); drive(z);
        @(negedge clk);
        chk("stall after valid", 32'(mem_valid), 32'h0);
        chk("stall after err",   32'(err),       32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/opicorv32_mem_arbiter.md
Name: opicorv32_mem_arbiter

Overview:
Shares the single native memory port between two requesters: port 0 is the core's mem_do_rinst/rdata/wdata engine and port 1 is the debug/DMA master. Fixed priority goes to port 0, with a starvation guard that forces a port-1 grant after a bounded run of port-0 grants. One transaction is outstanding at a time. The block sits between the control/memory-interface logic and the external memory bus.

Parameters:
STARVE_LIMIT, 4, number of consecutive port-0 grants allowed while port 1 is waiting; after that, port 1 is granted (range 1..15).
TIMEOUT_CYCLES, 255, cycles a granted transaction may wait for mem_ready before it is aborted (used only with the optional feature).

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
m0_valid  in  1  port 0 request; held until m0_ready
m0_instr  in  1  port 0 instruction-fetch qualifier
m0_addr  in  32  port 0 byte address
m0_wdata  in  32  port 0 write data
m0_wstrb  in  4  port 0 byte strobes; 0 means read
m0_ready  out  1  port 0 completion pulse
m0_rdata  out  32  port 0 read data, valid with m0_ready
m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata  as port 0, for port 1
mem_valid  out  1  downstream request
mem_instr  out  1  downstream fetch qualifier
mem_addr  out  32  downstream address
mem_wdata  out  32  downstream write data
mem_wstrb  out  4  downstream strobes
mem_ready  in  1  downstream completion
mem_rdata  in  32  downstream read data
grant  out  2  one-hot owner of the current transaction; 00 when idle
err  out  1  sticky timeout flag

Behaviour:
- Reset values: mem_valid=0, mem_instr=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, grant=00, m0_ready=0, m1_ready=0, m0_rdata=0, m1_rdata=0, err=0, starvation count=0, state=IDLE. Reset asserted mid-transaction drops mem_valid immediately (asynchronous) and discards the transaction.
- States: IDLE and BUSY.
- IDLE:
  - If any mX_valid is high, pick a winner and register the winner's instr/addr/wdata/wstrb onto mem_*.
  - At the same edge, set mem_valid=1, set grant, and go to BUSY.
  - Request-to-mem_valid latency is 1 cycle.
- Pick rule, when both ports are valid: port 0 wins unless starve_cnt==STARVE_LIMIT, in which case port 1 wins.
- starve_cnt:
  - increments, saturating, on each port-0 grant made while m1_valid is high;
  - clears on any port-1 grant;
  - is unchanged otherwise.
- BUSY:
  - mem_* outputs are held stable.
  - The granted port's mX_ready is a combinational copy of mem_ready, and mX_rdata = mem_rdata.
  - The non-granted port sees ready=0 and rdata=0.
  - On the edge where mem_ready=1: mem_valid←0, grant←00, go to IDLE.
  - The next arbitration happens in the following cycle, so a requester that drops valid on seeing ready is never re-issued.
- A requester deasserting valid while granted is a protocol violation. The transaction still completes, and the ready pulse is delivered regardless.
- The non-granted request waits. Its inputs are sampled only when it is granted.
- mem_ready while IDLE is ignored.

Optional Feature:
OPICORV32_MEM_TIMEOUT_EN
- Enabled:
  - An 8-bit-or-wider wait counter clears on entry to BUSY and increments each BUSY cycle without mem_ready.
  - When it reaches TIMEOUT_CYCLES, the transaction is aborted: the granted port gets a one-cycle ready with rdata=32'hDEAD_BEEF, mem_valid←0, state←IDLE, and err←1.
  - err stays at 1 until reset.
  - mem_ready arriving in the abort cycle takes precedence: normal completion, no error.
- Disabled: no counter; BUSY waits indefinitely; err tied to 0.

Decomposition:
- Shared package opicorv32_mem_pkg holds:
  - the state enum (IDLE, BUSY);
  - port-index constants PORT_CORE=0 and PORT_DBG=1;
  - the abort data constant 32'hDEAD_BEEF;
  - the grant one-hot encodings.
- One sub-module, opicorv32_mem_arb_pick: combinational winner selection plus the starvation counter register; it takes clk and reset.

Test Plan:
1. Single port-0 read, memory responds 2 cycles after mem_valid with rdata=0x12345678 → mem_valid rises 1 cycle after m0_valid; grant=01; m0_ready pulses once with m0_rdata=0x12345678; m1_ready stays 0.
2. Both ports valid continuously, STARVE_LIMIT=4, mem_ready after 1 cycle → grant sequence is 01,01,01,01,10,01…; starve_cnt clears after the port-1 grant.
3. Port-1 write, addr=0x100, wdata=0xA5A5A5A5, wstrb=0xF, port-0 idle → mem_* carry exactly those values; they stay stable until mem_ready; then grant=00 the next cycle.
4. Reset asserted in BUSY → mem_valid, grant and ready drop with no clock edge; after release the state is IDLE and starve_cnt=0.
5. With OPICORV32_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=8, mem_ready never asserted → after 8 BUSY cycles, m0_ready pulses with 0xDEADBEEF, err=1 and stays set; the next request proceeds normally.
6. With OPICORV32_MEM_TIMEOUT_EN, mem_ready asserted exactly in the timeout cycle → normal completion with memory rdata; err stays 0.
